cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
- Shares the single request port of the downstream direct-mapped cache FSM between two requesters:
  - exchange-side writes, which update a client's cancelled amount;
  - upstream CPU-side reads, which fetch a client's cancelled amount for the safe-to-trade check.
- Buffers exchange writes in a small FIFO and holds one pending CPU read.
- Sequences one cache transaction at a time and returns read data to the upstream side with an explicit valid.
- Sits between upstream_processor_top, downstream_top and dm_cache_fsm_downstream.

Parameters:
- ID_W, 5: client id width.
- AMT_W, 16: order amount width.
- FIFO_DEPTH, 4: exchange write buffer entries; power of 2, at least 2.
- STARVE_LIMIT, 3: consecutive read grants allowed while writes wait.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  exchange write request.
- ex_ready  out  1  write accepted when ex_valid && ex_ready.
- ex_client_id  in  ID_W  client to update.
- ex_amount  in  AMT_W  cancelled amount to store.
- cpu_valid  in  1  CPU read request.
- cpu_ready  out  1  read accepted when cpu_valid && cpu_ready.
- cpu_client_id  in  ID_W  client to look up.
- cpu_rsp_valid  out  1  one-cycle pulse; cpu_rsp_data is valid.
- cpu_rsp_data  out  32  cancelled amount read.
- cache_req_valid  out  1  request to cache FSM.
- cache_req_rw  out  1  1 = write, 0 = read.
- cache_req_index  out  32  {18'b0, 10-bit zero-extended client id, 4'b0}.
- cache_req_data  out  32  {16'b0, amount}.
- cache_res_ready  in  1  cache FSM done.
- cache_res_data  in  32  cache FSM read data.
- busy  out  1  FSM not in IDLE, or FIFO non-empty, or read pending.

Behaviour:
Reset:
- Reset is sampled on the rising clk edge.
- All outputs are 0 after the reset edge, except ex_ready = 1 and cpu_ready = 1.
- FIFO is emptied, rd_pending is cleared, starve_cnt is set to 0, FSM goes to IDLE.
- Reset mid-transaction abandons the transaction; a cache_res_ready arriving later is ignored.

Input side:
- ex_ready = !fifo_full.
- A push stores {id, amount}; a push on a full FIFO cannot occur.
- cpu_ready = !rd_pending.
- An accepted read latches its id and sets rd_pending.
- Push and pop in the same cycle are legal; a push while full stays blocked even if a pop happens that cycle (ex_ready is registered-state based).

FSM:
- IDLE:
  - Grant is evaluated when rd_pending or the FIFO is non-empty.
  - Grant write if the FIFO is non-empty and any of:
    - no read is pending;
    - starve_cnt == STARVE_LIMIT;
    - any FIFO entry id == the pending read id (RAW hazard: the write drains first).
  - Otherwise grant read.
  - Go to REQ on the next edge.
  - A request accepted this cycle is eligible next cycle, never the same cycle.
- REQ:
  - cache_req_valid = 1; rw, index and data are held stable from the grant until exit.
  - Wait for cache_res_ready = 1; there is no timeout.
  - Write completion: pop the FIFO head, clear starve_cnt.
  - Read completion: capture cache_res_data, clear rd_pending, pulse cpu_rsp_valid = 1 on the next cycle with the captured data.
  - If the read was granted while the FIFO was non-empty, starve_cnt += 1, saturating at STARVE_LIMIT.
  - Then go to IDLE.
- A minimum of one IDLE cycle separates transactions, so cache_req_valid drops for at least one cycle between them.
- cpu_rsp_data holds its last value between pulses.
- Read latency is 3 cycles from acceptance when the port is idle and the cache answers in 1 cycle.
- cache_res_ready while in IDLE is ignored.
- Writes complete in FIFO order.

Optional Feature:
- Macro: RAW_FWD_EN.
- Defined:
  - A read whose id matches a FIFO entry does not access the cache.
  - The amount of the youngest matching entry is returned zero-extended, with cpu_rsp_valid 1 cycle after acceptance.
  - The read never sets rd_pending; the FIFO is unaffected.
  - The match compare covers valid entries only and includes an entry pushed in the same cycle.
- Undefined: the RAW hazard forces write drains as described in Behaviour; no forwarding logic is built.

Test Plan:
1. Reset, then write id 3 amount 0x0010, then read id 3.
   - One write transaction with cache_req_index = 0x30 and cache_req_data = 0x10, then one read.
   - cpu_rsp_data = 0x10 returned from the cache model.
2. Fill the FIFO with 4 writes (ids 1-4) while the cache model stalls 5 cycles per request.
   - ex_ready = 0 after the 4th push and re-asserts the cycle after the first pop.
   - Writes complete in order 1, 2, 3, 4.
3. Starvation: keep the FIFO non-empty and issue back-to-back reads of id 9 (no id match).
   - Exactly 3 reads are granted, then 1 write, then starve_cnt is 0 and reads resume.
4. RAW: push write id 7 amount 0x0025 and read id 7 in the same cycle.
   - Without RAW_FWD_EN: the write is issued first, and the read returns 0x25 from the cache.
   - With RAW_FWD_EN: cpu_rsp_valid the next cycle with 0x25, and no cache read is issued.
5. Reset asserted while in REQ with a read pending.
   - Next cycle: cache_req_valid = 0, cpu_ready = 1, FIFO empty.
   - A late cache_res_ready produces no cpu_rsp_valid.
6. Simultaneous push and pop at FIFO_DEPTH-1 occupancy.
   - Occupancy is unchanged and the data order is preserved across pointer wrap-around.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Shares the cache FSM request port between buffered exchange writes and one pending CPU read.
// Optional build macro RAW_FWD_EN: reads that hit a buffered write are answered from the FIFO.
module cache_port_arbiter #(
   parameter int ID_W         = 5,
   parameter int AMT_W        = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   output logic             ex_ready,
   input  logic [ID_W-1:0]  ex_client_id,
   input  logic [AMT_W-1:0] ex_amount,
   input  logic             cpu_valid,
   output logic             cpu_ready,
   input  logic [ID_W-1:0]  cpu_client_id,
   output logic             cpu_rsp_valid,
   output logic [31:0]      cpu_rsp_data,
   output logic             cache_req_valid,
   output logic             cache_req_rw,
   output logic [31:0]      cache_req_index,
   output logic [31:0]      cache_req_data,
   input  logic             cache_res_ready,
   input  logic [31:0]      cache_res_data,
   output logic             busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] REQ  = 1'b1;

   logic [ID_W-1:0]  fifo_id_mem  [FIFO_DEPTH];
   logic [AMT_W-1:0] fifo_amt_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
   logic [CNT_W-1:0] count_reg;

   logic             rd_pending_reg;
   logic [ID_W-1:0]  rd_id_reg;
   logic [SC_W-1:0]  starve_cnt_reg;
   logic [0:0]       state_reg;
   logic             gap_reg;
   logic             req_rw_reg;
   logic [ID_W-1:0]  req_id_reg;
   logic [AMT_W-1:0] req_amt_reg;
   logic             read_starve_reg;
   logic             rsp_valid_reg;
   logic [31:0]      rsp_data_reg;

   logic fifo_full, fifo_empty, push, pop, rd_accept, rd_queue, rd_fwd;
   logic grant_write, grant_read;
   logic [31:0] fwd_data;
   logic [FIFO_DEPTH-1:0] raw_match;
   logic [9:0] id_ext;

   assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_reg == '0);
   assign push       = ex_valid && !fifo_full;
   assign pop        = (state_reg == REQ) && cache_res_ready && req_rw_reg;
   assign rd_accept  = cpu_valid && !rd_pending_reg;

   // An entry is live when its distance from the read pointer is below the occupancy.
   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_raw
         logic [PTR_W-1:0] age;
         assign age           = PTR_W'(gi) - rd_ptr_reg;
         assign raw_match[gi] = (CNT_W'(age) < count_reg) && (fifo_id_mem[gi] == rd_id_reg);
      end
   endgenerate

`ifdef RAW_FWD_EN
   logic             fwd_hit;
   logic [AMT_W-1:0] fwd_amt;
   // Walk oldest to youngest so the youngest match wins; a same-cycle push is youngest of all.
   always_comb begin
      fwd_hit = 1'b0;
      fwd_amt = '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         if ((CNT_W'(k) < count_reg) &&
             (fifo_id_mem[rd_ptr_reg + PTR_W'(k)] == cpu_client_id)) begin
            fwd_hit = 1'b1;
            fwd_amt = fifo_amt_mem[rd_ptr_reg + PTR_W'(k)];
         end
      end
      if (push && (ex_client_id == cpu_client_id)) begin
         fwd_hit = 1'b1;
         fwd_amt = ex_amount;
      end
   end
   assign rd_fwd   = rd_accept && fwd_hit;
   assign rd_queue = rd_accept && !fwd_hit;
   assign fwd_data = 32'(fwd_amt);
`else
   assign rd_fwd   = 1'b0;
   assign rd_queue = rd_accept;
   assign fwd_data = '0;
`endif

   assign grant_write = !fifo_empty &&
                        (!rd_pending_reg || (starve_cnt_reg == SC_W'(STARVE_LIMIT)) || (|raw_match));
   assign grant_read  = rd_pending_reg && !grant_write;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_id_mem[wr_ptr_reg]  <= ex_client_id;
         fifo_amt_mem[wr_ptr_reg] <= ex_amount;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_reg      <= '0;
         wr_ptr_reg      <= '0;
         count_reg       <= '0;
         rd_pending_reg  <= 1'b0;
         rd_id_reg       <= '0;
         starve_cnt_reg  <= '0;
         state_reg       <= IDLE;
         gap_reg         <= 1'b0;
         req_rw_reg      <= 1'b0;
         req_id_reg      <= '0;
         req_amt_reg     <= '0;
         read_starve_reg <= 1'b0;
         rsp_valid_reg   <= 1'b0;
         rsp_data_reg    <= '0;
      end else begin
         gap_reg       <= 1'b0;
         rsp_valid_reg <= 1'b0;
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
         else if (!push && pop) count_reg <= count_reg - CNT_W'(1);
         if (rd_queue) begin
            rd_pending_reg <= 1'b1;
            rd_id_reg      <= cpu_client_id;
         end
         if (rd_fwd) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= fwd_data;
         end
         if (state_reg == IDLE) begin
            // The settle cycle after each transaction lets a read accepted as the
            // previous read retires compete for the port before writes take it.
            if (!gap_reg && (grant_write || grant_read)) begin
               state_reg       <= REQ;
               req_rw_reg      <= grant_write;
               req_id_reg      <= grant_write ? fifo_id_mem[rd_ptr_reg] : rd_id_reg;
               req_amt_reg     <= grant_write ? fifo_amt_mem[rd_ptr_reg] : '0;
               read_starve_reg <= !fifo_empty;
            end
         end else if (cache_res_ready) begin
            state_reg <= IDLE;
            gap_reg   <= 1'b1;
            if (req_rw_reg) begin
               starve_cnt_reg <= '0;
            end else begin
               rd_pending_reg <= 1'b0;
               rsp_valid_reg  <= 1'b1;
               rsp_data_reg   <= cache_res_data;
               if (read_starve_reg && (starve_cnt_reg != SC_W'(STARVE_LIMIT)))
                  starve_cnt_reg <= starve_cnt_reg + SC_W'(1);
            end
         end
      end
   end

   assign id_ext          = 10'(req_id_reg);
   assign ex_ready        = !fifo_full;
   assign cpu_ready       = !rd_pending_reg;
   assign cpu_rsp_valid   = rsp_valid_reg;
   assign cpu_rsp_data    = rsp_data_reg;
   assign cache_req_valid = (state_reg == REQ);
   assign cache_req_rw    = req_rw_reg;
   assign cache_req_index = {18'b0, id_ext, 4'b0};
   assign cache_req_data  = 32'(req_amt_reg);
   assign busy            = (state_reg != IDLE) || !fifo_empty || rd_pending_reg;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: expected cache transactions and CPU responses are
// queued by the stimulus and consumed by independent monitors; a cache model answers requests.
module tb_cache_port_arbiter;

   logic        clk, rst;
   logic        ex_valid, ex_ready;
   logic [4:0]  ex_client_id;
   logic [15:0] ex_amount;
   logic        cpu_valid, cpu_ready;
   logic [4:0]  cpu_client_id;
   logic        cpu_rsp_valid;
   logic [31:0] cpu_rsp_data;
   logic        cache_req_valid, cache_req_rw;
   logic [31:0] cache_req_index, cache_req_data;
   logic        cache_res_ready;
   logic [31:0] cache_res_data;
   logic        busy;

   typedef struct packed {
      logic        rw;
      logic [31:0] index;
      logic [31:0] data;
   } txn_t;

   txn_t        exp_txn[$];
   logic [31:0] exp_rsp[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          stall    = 0;
   bit          model_en = 1'b1;
   logic [31:0] cache_mem [32];

   cache_port_arbiter dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_client_id(ex_client_id), .ex_amount(ex_amount),
      .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_client_id(cpu_client_id),
      .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
      .cache_req_valid(cache_req_valid), .cache_req_rw(cache_req_rw),
      .cache_req_index(cache_req_index), .cache_req_data(cache_req_data),
      .cache_res_ready(cache_res_ready), .cache_res_data(cache_res_data),
      .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   task automatic expect_txn(input logic rw, input logic [31:0] index, input logic [31:0] data);
      txn_t t;
      t.rw = rw; t.index = index; t.data = data;
      exp_txn.push_back(t);
   endtask

   task automatic do_write(input logic [4:0] id, input logic [15:0] amt);
      for (int i = 0; i < 100 && !ex_ready; i++) @(negedge clk);
      check("ex_ready_wait", ex_ready, 1);
      ex_valid = 1'b1; ex_client_id = id; ex_amount = amt;
      $display("push write id=%0d amount=0x%0h", id, amt);
      @(negedge clk);
      ex_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 && busy; i++) @(negedge clk);
      check("wait_idle", busy, 0);
      @(negedge clk);
   endtask

   // Cache model: answers each request after 'stall' extra cycles.
   bit in_txn = 1'b0;
   int wait_cnt = 0;
   always @(negedge clk) begin : cache_model
      if (model_en) begin
         if (cache_res_ready) begin
            cache_res_ready = 1'b0;
            in_txn = 1'b0;
         end else if (cache_req_valid) begin
            if (!in_txn) begin
               in_txn = 1'b1;
               wait_cnt = 0;
            end
            if (wait_cnt == stall) begin
               cache_res_ready = 1'b1;
               if (cache_req_rw) cache_mem[cache_req_index[8:4]] = cache_req_data;
               else cache_res_data = cache_mem[cache_req_index[8:4]];
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   txn_t cur_txn;
   bit   prev_req = 1'b0;
   always @(negedge clk) begin : txn_monitor
      if (cache_req_valid === 1'b1) begin
         if (!prev_req) begin
            $display("cache txn rw=%0d index=0x%0h data=0x%0h", cache_req_rw, cache_req_index, cache_req_data);
            if (exp_txn.size() == 0) begin
               n_checks++;
               $display("FAIL txn_unexpected: got rw=%0d index=0x%0h, expected no transaction",
                        cache_req_rw, cache_req_index);
            end else begin
               cur_txn = exp_txn.pop_front();
               check("txn_rw", {31'b0, cache_req_rw}, {31'b0, cur_txn.rw});
               check("txn_index", cache_req_index, cur_txn.index);
               check("txn_data", cache_req_data, cur_txn.data);
            end
         end else begin
            check("req_index_hold", cache_req_index, cur_txn.index);
            check("req_data_hold", cache_req_data, cur_txn.data);
         end
      end
      prev_req = (cache_req_valid === 1'b1);
   end

   always @(negedge clk) begin : rsp_monitor
      if (cpu_rsp_valid === 1'b1) begin
         $display("cpu rsp data=0x%0h", cpu_rsp_data);
         if (exp_rsp.size() == 0) begin
            n_checks++;
            $display("FAIL rsp_unexpected: got data=0x%0h, expected no response", cpu_rsp_data);
         end else begin
            check("rsp_data", cpu_rsp_data, exp_rsp.pop_front());
         end
      end
   end

   initial begin
      int n_acc;
      for (int i = 0; i < 32; i++) cache_mem[i] = '0;
      rst = 1'b1; ex_valid = 1'b0; ex_client_id = '0; ex_amount = '0;
      cpu_valid = 1'b0; cpu_client_id = '0; cache_res_ready = 1'b0; cache_res_data = '0;
      repeat (2) @(negedge clk);
      check("rst_ex_ready", ex_ready, 1);
      check("rst_cpu_ready", cpu_ready, 1);
      check("rst_req_valid", cache_req_valid, 0);
      check("rst_req_rw", cache_req_rw, 0);
      check("rst_req_index", cache_req_index, 0);
      check("rst_req_data", cache_req_data, 0);
      check("rst_rsp_valid", cpu_rsp_valid, 0);
      check("rst_rsp_data", cpu_rsp_data, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: write id 3 then read it back with single-cycle cache
      expect_txn(1'b1, 32'h30, 32'h10);
      do_write(5'd3, 16'h0010);
      wait_idle();
      expect_txn(1'b0, 32'h30, 32'h0);
      exp_rsp.push_back(32'h10);
      cpu_valid = 1'b1; cpu_client_id = 5'd3;
      $display("read id=3");
      @(negedge clk); cpu_valid = 1'b0;
      check("rd_lat_c1", cpu_rsp_valid, 0);
      @(negedge clk);
      check("rd_lat_c2", cpu_rsp_valid, 0);
      @(negedge clk);
      check("rd_lat_c3", cpu_rsp_valid, 1);
      @(negedge clk);
      check("rsp_pulse_end", cpu_rsp_valid, 0);
      check("rsp_data_hold", cpu_rsp_data, 32'h10);
      wait_idle();

      // 2: fill FIFO against a 5-cycle stalling cache
      stall = 5;
      for (int i = 1; i <= 4; i++) expect_txn(1'b1, 32'(i) << 4, 32'h100 + 32'(i));
      do_write(5'd1, 16'h0101);
      do_write(5'd2, 16'h0102);
      do_write(5'd3, 16'h0103);
      do_write(5'd4, 16'h0104);
      check("full_after_4", ex_ready, 0);
      repeat (3) begin
         @(negedge clk);
         check("full_hold", ex_ready, 0);
      end
      @(negedge clk);
      check("ex_ready_after_pop", ex_ready, 1);
      wait_idle();

      // 3: starvation limit with a write waiting behind back-to-back reads
      stall = 0;
      expect_txn(1'b1, 32'h90, 32'h99);
      do_write(5'd9, 16'h0099);
      wait_idle();
      repeat (3) expect_txn(1'b0, 32'h90, 32'h0);
      expect_txn(1'b1, 32'h50, 32'h55);
      repeat (2) expect_txn(1'b0, 32'h90, 32'h0);
      repeat (5) exp_rsp.push_back(32'h99);
      ex_valid = 1'b1; ex_client_id = 5'd5; ex_amount = 16'h0055;
      cpu_valid = 1'b1; cpu_client_id = 5'd9;
      $display("push write id=5 amount=0x55 with reads of id=9");
      n_acc = 0;
      for (int i = 0; i < 300; i++) begin
         if (cpu_ready) n_acc++;
         @(negedge clk);
         ex_valid = 1'b0;
         if (n_acc == 5) break;
      end
      cpu_valid = 1'b0;
      check("starve_accepts", n_acc, 5);
      wait_idle();

      // 4: same-cycle write and read of id 7
      expect_txn(1'b1, 32'h70, 32'h25);
`ifndef RAW_FWD_EN
      expect_txn(1'b0, 32'h70, 32'h0);
`endif
      exp_rsp.push_back(32'h25);
      ex_valid = 1'b1; ex_client_id = 5'd7; ex_amount = 16'h0025;
      cpu_valid = 1'b1; cpu_client_id = 5'd7;
      $display("push write id=7 amount=0x25 and read id=7");
      @(negedge clk);
      ex_valid = 1'b0; cpu_valid = 1'b0;
`ifdef RAW_FWD_EN
      check("fwd_rsp_valid", cpu_rsp_valid, 1);
      check("fwd_cpu_ready", cpu_ready, 1);
`endif
      wait_idle();

      // 5: reset while a read is in REQ; late completion must be ignored
      model_en = 1'b0;
      expect_txn(1'b0, 32'h90, 32'h0);
      cpu_valid = 1'b1; cpu_client_id = 5'd9;
      $display("read id=9 then reset mid-transaction");
      @(negedge clk); cpu_valid = 1'b0;
      for (int i = 0; i < 20 && !cache_req_valid; i++) @(negedge clk);
      check("req_before_reset", cache_req_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_req_valid", cache_req_valid, 0);
      check("mid_rst_cpu_ready", cpu_ready, 1);
      check("mid_rst_ex_ready", ex_ready, 1);
      check("mid_rst_busy", busy, 0);
      cache_res_ready = 1'b1; cache_res_data = 32'hDEAD;
      @(negedge clk);
      cache_res_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("late_res_no_rsp", cpu_rsp_valid, 0);
      end
      model_en = 1'b1;

      // 6: push and pop together at occupancy 3, order kept across wrap
      stall = 5;
      expect_txn(1'b1, 32'hA0, 32'hA1);
      expect_txn(1'b1, 32'hB0, 32'hB1);
      expect_txn(1'b1, 32'hC0, 32'hC1);
      expect_txn(1'b1, 32'hD0, 32'hD1);
      expect_txn(1'b1, 32'hE0, 32'hE1);
      do_write(5'd10, 16'h00A1);
      do_write(5'd11, 16'h00B1);
      do_write(5'd12, 16'h00C1);
      repeat (4) @(negedge clk);
      check("occ3_ready", ex_ready, 1);
      do_write(5'd13, 16'h00D1);
      check("pushpop_occ_kept", ex_ready, 1);
      do_write(5'd14, 16'h00E1);
      check("full_after_e", ex_ready, 0);
      wait_idle();

      check("exp_txn_drained", exp_txn.size(), 0);
      check("exp_rsp_drained", exp_rsp.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
